// File: rtl/unidade_controle_lobinho.sv
// Control unit for the werewolf ("lobinho") game: seed draw, per-player turns and night resolution.
// Moore FSM; control outputs are registered copies of the decode of the state being entered.
module unidade_controle_lobinho (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       confirmar,
  input  logic       reiniciar,
  input  logic       CJ_fim,
  output logic       zera_CS,
  output logic       inc_seed,
  output logic       e_seed_reg,
  output logic       rst_global,
  output logic       zera_CJ,
  output logic       inc_jogador,
  output logic       mostra_classe,
  output logic       processar_acao,
  output logic       avaliar_eliminacao,
  output logic       pronto,
  output logic       noite_concluida,
  output logic [2:0] rodada,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL    = 4'd0,
    SORTEIO    = 4'd1,
    ESPERA_ROM = 4'd2,
    REGISTRA   = 4'd3,
    NOVA_NOITE = 4'd4,
    MOSTRA     = 4'd5,
    PROCESSA   = 4'd6,
    PROXIMO    = 4'd7,
    AVALIA     = 4'd8,
    FIM_NOITE  = 4'd9
  } state_t;

  typedef struct packed {
    logic zera_cs;
    logic inc_seed;
    logic e_seed_reg;
    logic rst_global;
    logic zera_cj;
    logic inc_jogador;
    logic mostra_classe;
    logic processar_acao;
    logic avaliar_eliminacao;
    logic pronto;
    logic noite_concluida;
  } ctrl_t;

  // Plain vector rather than state_t so codes 10-15 are representable and recover.
  logic [3:0] state_q, state_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic [2:0] rodada_q, rodada_d;

  function automatic ctrl_t decode(input logic [3:0] s);
    ctrl_t c;
    c = '0;
    case (s)
      INICIAL:    begin c.rst_global = 1'b1; c.zera_cs = 1'b1; end
      SORTEIO:    begin c.inc_seed = 1'b1; c.pronto = 1'b1; end
      REGISTRA:   c.e_seed_reg = 1'b1;
      NOVA_NOITE: c.zera_cj = 1'b1;
      MOSTRA:     c.mostra_classe = 1'b1;
      PROCESSA:   begin c.mostra_classe = 1'b1; c.processar_acao = 1'b1; end
      PROXIMO:    c.inc_jogador = 1'b1;
      AVALIA:     c.avaliar_eliminacao = 1'b1;
      FIM_NOITE:  c.noite_concluida = 1'b1;
      default:    c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      INICIAL:    state_d = SORTEIO;
      SORTEIO:    if (iniciar) state_d = ESPERA_ROM;
      ESPERA_ROM: state_d = REGISTRA;
      REGISTRA:   state_d = NOVA_NOITE;
      NOVA_NOITE: state_d = MOSTRA;
      MOSTRA:     if (confirmar) state_d = PROCESSA;
      PROCESSA:   state_d = CJ_fim ? AVALIA : PROXIMO;
      PROXIMO:    state_d = MOSTRA;
      AVALIA:     state_d = FIM_NOITE;
      FIM_NOITE:  if (confirmar) state_d = NOVA_NOITE;
      default:    state_d = INICIAL;
    endcase
    if (reiniciar && state_q != INICIAL) state_d = INICIAL;

    rodada_d = rodada_q;
    if (state_d == INICIAL)                        rodada_d = 3'd0;
    else if (state_q == AVALIA && rodada_q != 3'd7) rodada_d = rodada_q + 3'd1;

    ctrl_d = decode(state_d);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= INICIAL;
      rodada_q <= 3'd0;
      ctrl_q   <= decode(INICIAL);
    end else begin
      state_q  <= state_d;
      rodada_q <= rodada_d;
      ctrl_q   <= ctrl_d;
    end
  end

  assign zera_CS            = ctrl_q.zera_cs;
  assign inc_seed           = ctrl_q.inc_seed;
  assign e_seed_reg         = ctrl_q.e_seed_reg;
  assign rst_global         = ctrl_q.rst_global;
  assign zera_CJ            = ctrl_q.zera_cj;
  assign inc_jogador        = ctrl_q.inc_jogador;
  assign mostra_classe      = ctrl_q.mostra_classe;
  assign processar_acao     = ctrl_q.processar_acao;
  assign avaliar_eliminacao = ctrl_q.avaliar_eliminacao;
  assign pronto             = ctrl_q.pronto;
  assign noite_concluida    = ctrl_q.noite_concluida;
  assign rodada             = rodada_q;
  assign db_estado          = state_q;

endmodule

// File: doc/unidade_controle_lobinho.md
UNIDADE_CONTROLE_LOBINHO -- requirements
Module: unidade_controle_lobinho

Interface
REQ-001 The block SHALL have these ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high; forces state INICIAL.
- iniciar  input  1  single-cycle pulse; starts a game from SORTEIO.
- confirmar  input  1  single-cycle pulse; player confirmed choice, or advance to next night.
- reiniciar  input  1  single-cycle pulse; abort the game and return to INICIAL.
- CJ_fim  input  1  player counter at last player (Q=4).
- zera_CS  output  1  clear seed counter.
- inc_seed  output  1  advance seed counter.
- e_seed_reg  output  1  load seed register.
- rst_global  output  1  clear seed register and datapath.
- zera_CJ  output  1  clear player counter.
- inc_jogador  output  1  advance player counter.
- mostra_classe  output  1  expose current player class.
- processar_acao  output  1  apply current player action.
- avaliar_eliminacao  output  1  resolve attack against protection.
- pronto  output  1  waiting for iniciar.
- noite_concluida  output  1  night resolved; waiting for confirmar or reiniciar.
- rodada  output  3  number of completed nights.
- db_estado  output  4  current state code.

Function
REQ-002 The block SHALL be a Moore FSM: every control output SHALL be decoded from the current state only.
REQ-003 The states and their codes SHALL be: INICIAL=0, SORTEIO=1, ESPERA_ROM=2, REGISTRA=3, NOVA_NOITE=4, MOSTRA=5, PROCESSA=6, PROXIMO=7, AVALIA=8, FIM_NOITE=9. Codes 10-15 SHALL go to INICIAL on the next cycle.
REQ-004 In INICIAL, rst_global=1 and zera_CS=1; the next state SHALL be SORTEIO unconditionally.
REQ-005 In SORTEIO, inc_seed=1 and pronto=1.
- If iniciar=1, the next state SHALL be ESPERA_ROM; otherwise the state stays.
- This makes the seed index depend on how long the FSM idles.
REQ-006 ESPERA_ROM SHALL assert no control output and SHALL go to REGISTRA. This one cycle covers the synchronous seed-ROM read latency.
REQ-007 REGISTRA SHALL assert e_seed_reg=1 for exactly one cycle and SHALL go to NOVA_NOITE.
REQ-008 NOVA_NOITE SHALL assert zera_CJ=1 and SHALL go to MOSTRA.
REQ-009 MOSTRA SHALL assert mostra_classe=1.
- On confirmar=1 the next state SHALL be PROCESSA; otherwise the state stays.
REQ-010 PROCESSA SHALL assert mostra_classe=1 and processar_acao=1 for exactly one cycle.
- If CJ_fim=1, the next state SHALL be AVALIA; otherwise it SHALL be PROXIMO.
REQ-011 PROXIMO SHALL assert inc_jogador=1 for one cycle and SHALL go to MOSTRA.
REQ-012 AVALIA SHALL assert avaliar_eliminacao=1 for one cycle and SHALL go to FIM_NOITE.
REQ-013 FIM_NOITE SHALL assert noite_concluida=1.
- On confirmar=1 the next state SHALL be NOVA_NOITE; otherwise the state stays.
REQ-014 When reiniciar=1 in any state other than INICIAL, the next state SHALL be INICIAL. reiniciar SHALL take priority over iniciar and confirmar sampled in the same cycle.
REQ-015 All control outputs not listed for a state SHALL be 0 in that state.
REQ-016 rodada:
- It SHALL clear to 0 in INICIAL.
- It SHALL increment by 1 on the clock edge that leaves AVALIA.
- It SHALL saturate at 7 (no wrap).
REQ-017 iniciar SHALL be ignored in every state except SORTEIO. confirmar SHALL be ignored in every state except MOSTRA and FIM_NOITE.
REQ-018 One night with 5 players SHALL take exactly 5 confirmar pulses, 5 processar_acao pulses, 4 inc_jogador pulses and 1 avaliar_eliminacao pulse.

Reset
REQ-019 While reset=1 at a rising edge, the next state SHALL be INICIAL and rodada SHALL be 0.
- reset SHALL override reiniciar, iniciar and confirmar.
- Reset in mid-night SHALL discard the night with no further processar_acao or avaliar_eliminacao.
REQ-020 In the first cycle after reset is released, the FSM SHALL be in INICIAL with rst_global=1 and zera_CS=1, and all other control outputs SHALL be 0.

Verification
REQ-021 Reset, then idle 7 cycles, then pulse iniciar:
- db_estado goes 0 -> 1 (x7+) -> 2 -> 3 -> 4 -> 5.
- e_seed_reg=1 in exactly one cycle (state 3).
- inc_seed is high every SORTEIO cycle.
REQ-022 Full night with CJ_fim modelled by a 0..4 counter, 5 confirmar pulses:
- Exactly 5 processar_acao pulses, 4 inc_jogador pulses and 1 avaliar_eliminacao pulse.
- End state FIM_NOITE (9), noite_concluida=1, rodada=1.
REQ-023 Nine complete nights: rodada reads 1..7, then holds at 7 for nights 8 and 9.
REQ-024 reiniciar and confirmar pulsed in the same cycle while in MOSTRA:
- Next state is INICIAL (0), not PROCESSA.
- rst_global=1 and rodada=0 in that next state.
REQ-025 reset asserted while in PROCESSA with CJ_fim=1:
- No avaliar_eliminacao pulse occurs.
- db_estado=0 on the following cycle.
REQ-026 Stray pulses ignored:
- confirmar pulsed in SORTEIO: no state change.
- iniciar pulsed in MOSTRA: no state change.
- Force db_estado to 12: next cycle db_estado=0.
